// File: rtl/iq_agc_sat_ctrl.sv
// Receive IQ automatic gain control: gain scaling with output saturation,
// per-window clip/peak statistics and a clip/low-signal driven gain loop.
module iq_agc_sat_ctrl #(
    parameter int ISZ      = 12,
    parameter int OSZ      = 12,
    parameter int GSZ      = 8,
    parameter int GFRAC    = 4,
    parameter int WIN_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [GSZ-1:0]        manual_gain,
    input  logic [WIN_LOG2:0]     clip_thresh,
    input  logic [OSZ-2:0]        low_thresh,
    input  logic                  in_valid,
    input  logic signed [ISZ-1:0] in_i,
    input  logic signed [ISZ-1:0] in_q,
    output logic                  out_valid,
    output logic signed [OSZ-1:0] out_i,
    output logic signed [OSZ-1:0] out_q,
    output logic                  out_clip,
    output logic [GSZ-1:0]        gain,
    output logic [WIN_LOG2:0]     clip_count,
    output logic [OSZ-2:0]        peak,
    output logic                  update
);

    localparam int PW = ISZ + GSZ + 1;
    localparam int CW = WIN_LOG2 + 1;
    localparam int MW = OSZ - 1;
    localparam logic [GSZ-1:0] GAIN_RST = GSZ'(1 << GFRAC);
    localparam logic [GSZ-1:0] GAIN_ONE = GSZ'(1);

    typedef enum logic [1:0] {IDLE, TRACK, ADJUST} state_t;

    state_t                state_q, state_d;
    logic [GSZ-1:0]        gain_q, gain_d;
    logic                  v1_q, v1_d;
    logic signed [PW-1:0]  p_i_q, p_i_d, p_q_q, p_q_d;
    logic                  v2_q, v2_d;
    logic signed [OSZ-1:0] o_i_q, o_i_d, o_q_q, o_q_d;
    logic                  clip_q, clip_d;
    logic [WIN_LOG2-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]         clip_acc_q, clip_acc_d;
    logic [MW-1:0]         peak_acc_q, peak_acc_d;
    logic [CW-1:0]         clip_count_q, clip_count_d;
    logic [MW-1:0]         peak_q, peak_d;
    logic                  update_q, update_d;

    logic [OSZ:0]          sat_i, sat_q;
    logic [MW-1:0]         mag_i, mag_q, smp_mag, peak_new;
    logic [CW-1:0]         clip_sum;
    logic [GSZ-1:0]        dec;

    function automatic logic signed [PW-1:0] sext(input logic signed [ISZ-1:0] x);
        return {{(PW-ISZ){x[ISZ-1]}}, x};
    endfunction

    // Returns {clipped, value}; the product is in range when all bits above
    // the output sign bit agree with it.
    function automatic logic [OSZ:0] saturate(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] s;
        logic [PW-OSZ:0]      top;
        s   = p >>> GFRAC;
        top = s[PW-1:OSZ-1];
        if (top == '0 || top == '1)
            return {1'b0, s[OSZ-1:0]};
        else if (s[PW-1])
            return {1'b1, 1'b1, {(OSZ-1){1'b0}}};
        else
            return {1'b1, 1'b0, {(OSZ-1){1'b1}}};
    endfunction

    function automatic logic [MW-1:0] magnitude(input logic signed [OSZ-1:0] o);
        logic [OSZ-1:0] n;
        n = -o;
        if (!o[OSZ-1])
            return o[MW-1:0];
        if (o[MW-1:0] == '0)
            return '1;
        return n[MW-1:0];
    endfunction

    always_comb begin
        v1_d  = in_valid;
        p_i_d = p_i_q;
        p_q_d = p_q_q;
        if (in_valid) begin
            p_i_d = sext(in_i) * $signed({{(PW-GSZ){1'b0}}, gain_q});
            p_q_d = sext(in_q) * $signed({{(PW-GSZ){1'b0}}, gain_q});
        end

        sat_i  = saturate(p_i_q);
        sat_q  = saturate(p_q_q);
        v2_d   = v1_q;
        o_i_d  = o_i_q;
        o_q_d  = o_q_q;
        clip_d = 1'b0;
        if (v1_q) begin
            o_i_d  = sat_i[OSZ-1:0];
            o_q_d  = sat_q[OSZ-1:0];
            clip_d = sat_i[OSZ] | sat_q[OSZ];
        end

        mag_i    = magnitude(o_i_q);
        mag_q    = magnitude(o_q_q);
        smp_mag  = (mag_i > mag_q) ? mag_i : mag_q;
        peak_new = (smp_mag > peak_acc_q) ? smp_mag : peak_acc_q;
        clip_sum = clip_acc_q + CW'(clip_q);
        dec      = ((gain_q >> 2) == '0) ? GAIN_ONE : (gain_q >> 2);

        state_d      = state_q;
        gain_d       = gain_q;
        cnt_d        = cnt_q;
        clip_acc_d   = clip_acc_q;
        peak_acc_d   = peak_acc_q;
        clip_count_d = clip_count_q;
        peak_d       = peak_q;
        update_d     = 1'b0;

        if (!enable) begin
            state_d    = IDLE;
            gain_d     = manual_gain;
            cnt_d      = '0;
            clip_acc_d = '0;
            peak_acc_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    gain_d  = manual_gain;
                    state_d = TRACK;
                end
                TRACK, ADJUST: begin
                    if (state_q == ADJUST) begin
                        state_d = TRACK;
                        if (clip_count_q > clip_thresh)
                            gain_d = (gain_q > dec) ? (gain_q - dec) : GAIN_ONE;
                        else if (peak_q < low_thresh && gain_q != '1)
                            gain_d = gain_q + GAIN_ONE;
                    end
                    // A sample emerging during ADJUST opens the next window.
                    if (v2_q) begin
                        if (state_q == TRACK && cnt_q == '1) begin
                            clip_count_d = clip_sum;
                            peak_d       = peak_new;
                            cnt_d        = '0;
                            clip_acc_d   = '0;
                            peak_acc_d   = '0;
                            state_d      = ADJUST;
                            update_d     = 1'b1;
                        end else begin
                            cnt_d      = cnt_q + WIN_LOG2'(1);
                            clip_acc_d = clip_sum;
                            peak_acc_d = peak_new;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gain_q       <= GAIN_RST;
            v1_q         <= 1'b0;
            p_i_q        <= '0;
            p_q_q        <= '0;
            v2_q         <= 1'b0;
            o_i_q        <= '0;
            o_q_q        <= '0;
            clip_q       <= 1'b0;
            cnt_q        <= '0;
            clip_acc_q   <= '0;
            peak_acc_q   <= '0;
            clip_count_q <= '0;
            peak_q       <= '0;
            update_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            gain_q       <= gain_d;
            v1_q         <= v1_d;
            p_i_q        <= p_i_d;
            p_q_q        <= p_q_d;
            v2_q         <= v2_d;
            o_i_q        <= o_i_d;
            o_q_q        <= o_q_d;
            clip_q       <= clip_d;
            cnt_q        <= cnt_d;
            clip_acc_q   <= clip_acc_d;
            peak_acc_q   <= peak_acc_d;
            clip_count_q <= clip_count_d;
            peak_q       <= peak_d;
            update_q     <= update_d;
        end
    end

    assign out_valid  = v2_q;
    assign out_i      = o_i_q;
    assign out_q      = o_q_q;
    assign out_clip   = clip_q;
    assign gain       = gain_q;
    assign clip_count = clip_count_q;
    assign peak       = peak_q;
    assign update     = update_q;

endmodule

// File: tb/tb_iq_agc_sat_ctrl.sv
// Scoreboard bench for iq_agc_sat_ctrl with a 16-sample window: directed
// samples push hand-computed outputs, a negedge monitor pops and compares.
module tb_iq_agc_sat_ctrl;

    logic               clk;
    logic               rst;
    logic               enable;
    logic [7:0]         manual_gain;
    logic [4:0]         clip_thresh;
    logic [10:0]        low_thresh;
    logic               in_valid;
    logic signed [11:0] in_i;
    logic signed [11:0] in_q;
    logic               out_valid;
    logic signed [11:0] out_i;
    logic signed [11:0] out_q;
    logic               out_clip;
    logic [7:0]         gain;
    logic [4:0]         clip_count;
    logic [10:0]        peak;
    logic               update;

    typedef struct {int i; int q; bit clip;} sample_t;
    typedef struct {int cc; int pk;} win_t;

    sample_t sb_q[$];
    win_t    win_q[$];
    int      n_checks = 0;
    int      n_fail   = 0;

    iq_agc_sat_ctrl #(
        .ISZ(12), .OSZ(12), .GSZ(8), .GFRAC(4), .WIN_LOG2(4)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .manual_gain(manual_gain),
        .clip_thresh(clip_thresh), .low_thresh(low_thresh),
        .in_valid(in_valid), .in_i(in_i), .in_q(in_q),
        .out_valid(out_valid), .out_i(out_i), .out_q(out_q), .out_clip(out_clip),
        .gain(gain), .clip_count(clip_count), .peak(peak), .update(update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input int i, input int q, input int ei, input int eq, input bit ec);
        sample_t s;
        s.i = ei; s.q = eq; s.clip = ec;
        sb_q.push_back(s);
        in_valid = 1'b1;
        in_i = 12'(i);
        in_q = 12'(q);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_window(input int cc, input int pk);
        win_t w;
        w.cc = cc; w.pk = pk;
        win_q.push_back(w);
    endtask

    // Reload the gain from manual_gain through IDLE, then leave enable as given.
    task automatic seed_gain(input int g, input bit en);
        manual_gain = 8'(g);
        enable = 1'b0;
        wait_cycles(2);
        enable = en;
        wait_cycles(1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check_output("unexpected_out_valid", 1, 0);
                end else begin
                    sample_t s;
                    s = sb_q.pop_front();
                    check_output("out_i", int'(out_i), s.i);
                    check_output("out_q", int'(out_q), s.q);
                    check_output("out_clip", int'(out_clip), int'(s.clip));
                end
            end
            if (update) begin
                if (win_q.size() == 0) begin
                    check_output("unexpected_update", 1, 0);
                end else begin
                    win_t w;
                    w = win_q.pop_front();
                    check_output("clip_count", int'(clip_count), w.cc);
                    check_output("peak", int'(peak), w.pk);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        manual_gain = 8'd16;
        clip_thresh = 5'd3;
        low_thresh = 11'd512;
        in_valid = 1'b0;
        in_i = '0;
        in_q = '0;
        wait_cycles(2);
        check_output("rst_out_valid", int'(out_valid), 0);
        check_output("rst_out_i", int'(out_i), 0);
        check_output("rst_out_clip", int'(out_clip), 0);
        check_output("rst_update", int'(update), 0);
        check_output("rst_gain", int'(gain), 16);
        check_output("rst_clip_count", int'(clip_count), 0);
        check_output("rst_peak", int'(peak), 0);
        rst = 1'b0;
        wait_cycles(2);

        apply_stimulus(1000, -3, 1000, -3, 0);
        apply_stimulus(-2048, 2047, -2048, 2047, 0);
        wait_cycles(4);

        seed_gain(32, 0);
        apply_stimulus(1500, -2048, 2047, -2048, 1);
        apply_stimulus(100, -100, 200, -200, 0);
        wait_cycles(4);

        seed_gain(24, 0);
        apply_stimulus(-3, 5, -5, 7, 0);
        apply_stimulus(2047, -2048, 2047, -2048, 1);
        wait_cycles(4);
        check_output("manual_gain_24", int'(gain), 24);

        seed_gain(64, 1);
        expect_window(16, 2047);
        for (int k = 0; k < 16; k++) apply_stimulus(1000, 0, 2047, 0, 1);
        wait_cycles(5);
        check_output("gain_clip_down", int'(gain), 48);

        seed_gain(16, 1);
        expect_window(0, 100);
        for (int k = 0; k < 16; k++) apply_stimulus(100, 0, 100, 0, 0);
        wait_cycles(5);
        check_output("gain_low_up", int'(gain), 17);

        seed_gain(255, 1);
        expect_window(0, 16);
        for (int k = 0; k < 16; k++) apply_stimulus(1, -1, 15, -16, 0);
        wait_cycles(5);
        check_output("gain_max_hold", int'(gain), 255);

        low_thresh = 11'd100;
        seed_gain(1, 1);
        expect_window(0, 127);
        for (int k = 0; k < 16; k++) apply_stimulus(2047, 0, 127, 0, 0);
        wait_cycles(5);
        check_output("gain_one_hold", int'(gain), 1);

        low_thresh = 11'd512;
        seed_gain(16, 1);
        for (int k = 0; k < 7; k++) apply_stimulus(100, 0, 100, 0, 0);
        wait_cycles(4);
        manual_gain = 8'd20;
        enable = 1'b0;
        wait_cycles(1);
        check_output("drop_gain_manual", int'(gain), 20);
        check_output("drop_clip_count_kept", int'(clip_count), 0);
        check_output("drop_peak_kept", int'(peak), 127);
        enable = 1'b1;
        wait_cycles(1);
        for (int k = 0; k < 15; k++) apply_stimulus(100, 0, 125, 0, 0);
        wait_cycles(5);
        check_output("partial_window_gain", int'(gain), 20);
        expect_window(0, 125);
        apply_stimulus(100, 0, 125, 0, 0);
        wait_cycles(5);
        check_output("full_window_gain", int'(gain), 21);

        for (int k = 0; k < 5; k++) apply_stimulus(100, 0, 131, 0, 0);
        rst = 1'b1;
        sb_q.delete();
        #1;
        check_output("midrst_out_valid", int'(out_valid), 0);
        check_output("midrst_out_i", int'(out_i), 0);
        check_output("midrst_update", int'(update), 0);
        check_output("midrst_gain", int'(gain), 16);
        check_output("midrst_clip_count", int'(clip_count), 0);
        check_output("midrst_peak", int'(peak), 0);
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(2);
        for (int k = 0; k < 10; k++) apply_stimulus(100, 0, 125, 0, 0);
        wait_cycles(6);
        check_output("post_rst_gain", int'(gain), 20);

        check_output("samples_pending", sb_q.size(), 0);
        check_output("windows_pending", win_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
